// File: rtl/two_sorter_reg.sv
// two_sorter_reg: registered compare-and-swap cell, min on c and max on d
module two_sorter_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d
);
  logic swap;
  assign swap = a > b;
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      c <= '0;
      d <= '0;
    end else begin
      c <= swap ? b : a;
      d <= swap ? a : b;
    end
endmodule

// File: tb/tb_two_sorter_reg.sv
// tb_two_sorter_reg: random and directed checks of the registered sorter against a sort-based model
module tb_two_sorter_reg;
  logic clk = 0;
  logic rstN = 1;
  logic [3:0] a = 0;
  logic [3:0] b = 0;
  logic [3:0] c;
  logic [3:0] d;
  int total = 0;
  int bad = 0;
  two_sorter_reg #(.WIDTH(4)) dut (.clk(clk), .rstN(rstN), .a(a), .b(b), .c(c), .d(d));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic apply(input int x, input int y, input string tag);
    int q[$];
    @(negedge clk);
    a = 4'(x);
    b = 4'(y);
    rstN = 1;
    q = '{x, y};
    q.sort();
    @(posedge clk);
    #1;
    chk({tag, ".c"}, int'(c), q[0]);
    chk({tag, ".d"}, int'(d), q[1]);
    chk({tag, ".ord"}, int'(c <= d), 1);
    chk({tag, ".sum"}, int'(c) + int'(d), x + y);
  endtask
  initial begin
    #2;
    rstN = 0;
    #1;
    chk("rst_async.c", int'(c), 0);
    chk("rst_async.d", int'(d), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold.c", int'(c), 0);
      chk("rst_hold.d", int'(d), 0);
    end
    @(negedge clk);
    a = 13;
    b = 2;
    @(posedge clk);
    #1;
    chk("rst_ign.c", int'(c), 0);
    chk("rst_ign.d", int'(d), 0);
    apply(3, 7, "dir0");
    apply(10, 2, "dir1");
    apply(0, 15, "dir2");
    apply(15, 0, "dir3");
    apply(7, 8, "dir4");
    apply(1, 14, "dir5");
    apply(5, 5, "eq5");
    apply(15, 15, "eq15");
    apply(0, 0, "eq0");
    apply(12, 8, "pipe0");
    apply(3, 9, "pipe1");
    apply(15, 0, "pipe2");
    apply(7, 7, "pipe3");
    apply(11, 4, "mid_pre");
    // assert reset mid-cycle while a new pair is on the inputs
    #2;
    a = 13;
    b = 2;
    rstN = 0;
    #1;
    chk("mid_async.c", int'(c), 0);
    chk("mid_async.d", int'(d), 0);
    @(posedge clk);
    #1;
    chk("mid_hold.c", int'(c), 0);
    chk("mid_hold.d", int'(d), 0);
    apply(8, 12, "mid_post0");
    apply(7, 3, "mid_post1");
    for (int i = 0; i < 30; i++) apply(int'($urandom_range(15)), int'($urandom_range(15)), "rnd");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/two_sorter_reg.md
# two_sorter_reg

Registered two-element compare-and-swap cell for sorting networks. It accepts two unsigned values each cycle and presents them in ascending order one clock later. The smaller value appears on `c` and the larger on `d`. It is the basic pipelined building block from which larger sorter and merger networks are tiled.

## Interface
Parameters:
- `WIDTH`, default 4: bit width of each data value (unsigned). The default instance uses 4.

Ports:
- `clk`, in, 1: single clock, rising-edge active.
- `rstN`, in, 1: asynchronous, active-low reset.
- `a`, in, WIDTH: first input value (unsigned).
- `b`, in, WIDTH: second input value (unsigned).
- `c`, out, WIDTH: registered minimum of `a` and `b`.
- `d`, out, WIDTH: registered maximum of `a` and `b`.

## Operation
- Comparison:
  - Unsigned, full-width compare of `a` against `b`.
  - If `a <= b`: next `c = a` and next `d = b`. Otherwise next `c = b` and next `d = a`.
- Equal inputs: both outputs take the common value. Tie-break selection has no observable effect.
- Data preservation: the output pair is always a permutation of the input pair. No arithmetic or width change; `c + d == a + b` as a multiset.
- Invariant: `c <= d` (unsigned) in every cycle, including directly after reset (0, 0).
- No handshake, no valid signal, no stall. A new pair is accepted every cycle.
- Outputs `c` and `d` come directly from flip-flops, with no combinational path from input to output.
- The compare/select logic is purely combinational, ahead of the registers.

## Timing
- Latency: exactly 1 cycle. Values on `a`/`b` sampled at rising edge N appear on `c`/`d` immediately after edge N and hold until edge N+1.
- Throughput: 1 pair per cycle. Back-to-back pairs emerge in input order, each one cycle after sampling.
- Reset:
  - When `rstN` goes low, `c` and `d` clear to 0 immediately, without waiting for a clock edge.
  - They stay 0 for as long as `rstN` is low. Inputs are ignored during reset, and values driven on `a`/`b` while in reset never reach the outputs.
- Reset release:
  - The first rising edge with `rstN` high samples the current `a`/`b`.
  - No extra recovery cycles are required beyond normal deassertion timing.
- Reset asserted mid-operation: any pair in flight is discarded, and outputs go to 0. Normal operation resumes after release with no residual state.
- Power-up: outputs are undefined until the first reset assertion. The bench resets before checking.

## Test plan
- Reset: hold `rstN=0` for 2 cycles with `a=0`, `b=0`, then `a=13`, `b=2` -> `c=0`, `d=0` throughout, including asynchronously on assertion.
- Directed sort, each pair applied and checked one clock later:
  - (3,7) -> `c=3`, `d=7`
  - (10,2) -> `c=2`, `d=10`
  - (0,15) -> `c=0`, `d=15`
  - (15,0) -> `c=0`, `d=15`
  - (7,8) -> `c=7`, `d=8`
  - (1,14) -> `c=1`, `d=14`
- Equal values:
  - (5,5) -> `c=5`, `d=5`
  - (15,15) -> `c=15`, `d=15`
  - (0,0) -> `c=0`, `d=0`
- Pipeline: drive (12,8), (3,9), (15,0), (7,7) on consecutive cycles -> outputs (8,12), (3,9), (0,15), (7,7) on the respective following cycles, with no bubbles.
- Reset mid-operation:
  - Apply (11,4) -> (4,11).
  - Assert `rstN=0` for 1 cycle while driving (13,2) -> `c=0`, `d=0`, and (13,2) is never output.
  - Release, then apply (8,12) -> (8,12). Also (7,3) after reset -> (3,7).
- Random: 20+ random 4-bit pairs. For each, check `c == min`, `d == max`, `c <= d`, and `c + d == a + b`, one cycle after application.
